// File: rtl/lb_pkg.sv
// Shared types and helpers for the 3x3 line buffer sequencer.
package lb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } lb_ctrl_state_e;

  localparam int LB_WIN_K = 3;

  // Row width in pixels for a given width code (4..512).
  function automatic logic [31:0] lb_width(input logic [2:0] sel);
    return 32'd4 << sel;
  endfunction

endpackage

// File: rtl/linebuffer_3x3_ctrl_if.sv
// Pixel input stream and window output handshake of the line buffer sequencer.
// Both channels: a transfer happens on a rising edge where valid && ready; valid
// and payload hold until then, and ready may depend combinationally on valid.
interface linebuffer_3x3_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 9
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              win_valid;
  logic              win_ready;
  logic [CNT_W-1:0]  win_row;
  logic [CNT_W-1:0]  win_col;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_row, win_col
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_row, win_col
  );
endinterface

// File: rtl/lb_rc_counter.sv
// Raster position counter: column wraps at the row width, flags the last pixel
// of the frame and whether the current pixel completes an in-image window.
module lb_rc_counter
  import lb_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [2:0]       sel,
  input  logic [CNT_W-1:0] height,
  input  logic             stride2,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             last,
  output logic             in_win
);
  localparam logic [31:0] K_M1 = 32'(LB_WIN_K - 1);

  logic col_end;

  assign col_end = (32'(col) == lb_width(sel) - 32'd1);
  assign last    = col_end && (32'(row) == 32'(height) - 32'd1);
  // Stride 2 keeps only windows whose top-left (r-2, c-2) is even in both axes.
  assign in_win  = (32'(row) >= K_M1) && (32'(col) >= K_M1) &&
                   (!stride2 || (!row[0] && !col[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/linebuffer_3x3_ctrl.sv
// Sequencer for the 3x3 line buffer: accepts raster pixels, drives the buffer and
// flags complete windows. Optional stride-2 window selection: LB_CTRL_STRIDE2_EN.
module linebuffer_3x3_ctrl
  import lb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            cfg_sel,
  input  logic [CNT_W-1:0]      cfg_height,
`ifdef LB_CTRL_STRIDE2_EN
  input  logic                  cfg_stride2,
`endif
  linebuffer_3x3_ctrl_if.slave  bus,
  output logic [2:0]            lb_sel,
  output logic                  lb_en,
  output logic [DATA_W-1:0]     lb_data,
  output logic                  busy,
  output logic                  done,
  output lb_ctrl_state_e        state_dbg
);
  lb_ctrl_state_e   state_q, state_d;
  logic [CNT_W-1:0] height_q;
  logic             stride_q;
  logic             win_valid_q;
  logic [CNT_W-1:0] win_row_q, win_col_q;
  logic             win_free, accept, launch;
  logic [CNT_W-1:0] row, col;
  logic             last, in_win;

  assign launch   = (state_q == IDLE) && start;
  // The buffer must not shift while an unconsumed window is on its output.
  assign win_free = !win_valid_q || bus.win_ready;
  assign bus.in_ready = (state_q == RUN) && win_free;
  assign accept   = bus.in_valid && bus.in_ready;

  assign lb_en         = accept;
  assign lb_data       = bus.in_data;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign state_dbg     = state_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

  lb_rc_counter #(.CNT_W(CNT_W)) u_rc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (launch),
    .inc     (accept),
    .sel     (lb_sel),
    .height  (height_q),
    .stride2 (stride_q),
    .row     (row),
    .col     (col),
    .last    (last),
    .in_win  (in_win)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last) state_d = DRAIN;
      DRAIN:   if (win_free) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lb_sel   <= '0;
      height_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        lb_sel   <= cfg_sel;
        height_q <= cfg_height;
      end
    end
  end

`ifdef LB_CTRL_STRIDE2_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stride_q <= 1'b0;
    else if (launch) stride_q <= cfg_stride2;
  end
`else
  assign stride_q = 1'b0;
`endif

  // A window appears one edge after its bottom-right pixel, in step with ifmap_3x3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (accept) begin
      win_valid_q <= in_win;
      if (in_win) begin
        win_row_q <= row - CNT_W'(LB_WIN_K - 1);
        win_col_q <= col - CNT_W'(LB_WIN_K - 1);
      end
    end else if (bus.win_ready) begin
      win_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// Self-checking bench for linebuffer_3x3_ctrl: frame-level model plus directed frames.
module tb_linebuffer_3x3_ctrl;
  import lb_pkg::*;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        cfg_sel = '0;
  logic [CNT_W-1:0]  cfg_height = '0;
  logic [2:0]        lb_sel;
  logic              lb_en;
  logic [DATA_W-1:0] lb_data;
  logic              busy, done;
  lb_ctrl_state_e    state_dbg;

  linebuffer_3x3_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  linebuffer_3x3_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_sel    (cfg_sel),
    .cfg_height (cfg_height),
`ifdef LB_CTRL_STRIDE2_EN
    .cfg_stride2(1'b0),
`endif
    .bus        (bus),
    .lb_sel     (lb_sel),
    .lb_en      (lb_en),
    .lb_data    (lb_data),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Phases: 0 idle, 1 accepting pixels, 2 draining last window, 3 done pulse.
  int               m_phase = 0;
  int               m_w = 4, m_h = 0, m_cnt = 0;
  logic [2:0]       m_sel = '0;
  logic             m_wv = 1'b0;
  logic [CNT_W-1:0] m_row = '0, m_col = '0;

  // observation tallies and literal scoreboard of {row, col}
  int   win_cnt, en_cnt, done_cnt, stall_cnt, first_en;
  bit   seen_first;
  logic [2*CNT_W-1:0] exp_q[$];

  logic c_rdy, c_acc, c_win;
  int   c_r, c_c;
  logic [2*CNT_W-1:0] c_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_lb_en", lb_en, 0);
      chk("rst_win_valid", bus.win_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_lb_sel", lb_sel, 0);
      chk("rst_win_row", bus.win_row, 0);
      chk("rst_win_col", bus.win_col, 0);
      chk("rst_state", state_dbg, IDLE);
      m_phase = 0;
      m_wv    = 1'b0;
      m_sel   = '0;
    end else begin
      c_rdy = (m_phase == 1) && (!m_wv || bus.win_ready);
      chk("in_ready", bus.in_ready, c_rdy);
      chk("lb_en", lb_en, bus.in_valid && c_rdy);
      chk("lb_data", lb_data, bus.in_data);
      chk("win_valid", bus.win_valid, m_wv);
      chk("busy", busy, (m_phase == 1) || (m_phase == 2));
      chk("done", done, m_phase == 3);
      chk("lb_sel", lb_sel, m_sel);
      if (m_wv) begin
        chk("win_row", bus.win_row, m_row);
        chk("win_col", bus.win_col, m_col);
      end

      if (bus.win_valid && !seen_first) begin
        seen_first = 1'b1;
        first_en   = en_cnt;
      end
      if (lb_en) en_cnt++;
      if (done) done_cnt++;
      if (bus.win_valid && !bus.win_ready) stall_cnt++;
      if (bus.win_valid && bus.win_ready) begin
        win_cnt++;
        if (exp_q.size() > 0) begin
          c_e = exp_q.pop_front();
          chk("win_literal", {bus.win_row, bus.win_col}, c_e);
        end
      end

      // advance the model across the coming edge
      c_acc = bus.in_valid && c_rdy;
      c_win = 1'b0;
      case (m_phase)
        0: if (start) begin
             m_phase = 1;
             m_sel   = cfg_sel;
             m_w     = 4 << cfg_sel;
             m_h     = int'(cfg_height);
             m_cnt   = 0;
           end
        1: if (c_acc) begin
             c_r = m_cnt / m_w;
             c_c = m_cnt % m_w;
             if (c_r >= 2 && c_c >= 2) begin
               c_win = 1'b1;
               m_row = CNT_W'(c_r - 2);
               m_col = CNT_W'(c_c - 2);
             end
             m_cnt++;
             if (m_cnt == m_w * m_h) m_phase = 2;
           end
        2: if (!m_wv || bus.win_ready) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (c_acc) m_wv = c_win;
      else if (bus.win_ready) m_wv = 1'b0;
    end
  end

  // ---------------- backpressure driver ----------------
  bit bp_arm = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (bp_arm && bus.win_valid) begin
        bp_arm = 1'b0;
        bus.win_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.win_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_counts();
    win_cnt = 0; en_cnt = 0; done_cnt = 0; stall_cnt = 0;
    first_en = -1; seen_first = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_start(input logic [2:0] sel, input int h);
    start = 1'b1;
    cfg_sel = sel;
    cfg_height = CNT_W'(h);
    step();
    start = 1'b0;
  endtask

  task automatic send_pixels(input int first, input int n, input bit bubble);
    bit ok;
    int tries;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(first + i);
      ok = 1'b0;
      tries = 0;
      while (!ok && tries < 200) begin
        @(negedge clk);
        ok = bus.in_ready;
        step();
        tries++;
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
      if (bubble) step();
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    step();
  endtask

  task automatic push_4x4_windows();
    exp_q.push_back({9'd0, 9'd0});
    exp_q.push_back({9'd0, 9'd1});
    exp_q.push_back({9'd1, 9'd0});
    exp_q.push_back({9'd1, 9'd1});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b1;
    clr_counts();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // basic 4x4 frame
    clr_counts();
    push_4x4_windows();
    do_start(3'd0, 4);
    send_pixels(0, 16, 1'b0);
    wait_done();
    chk("basic_windows", win_cnt, 4);
    chk("basic_done", done_cnt, 1);
    chk("basic_first_after_px10", first_en, 11);
    chk("basic_lb_en", en_cnt, 16);
    chk("basic_scoreboard_empty", exp_q.size(), 0);

    // backpressure on the first window
    clr_counts();
    push_4x4_windows();
    bp_arm = 1'b1;
    do_start(3'd0, 4);
    send_pixels(0, 16, 1'b0);
    wait_done();
    chk("bp_stall_cycles", stall_cnt, 5);
    chk("bp_windows", win_cnt, 4);
    chk("bp_lb_en", en_cnt, 16);
    chk("bp_done", done_cnt, 1);

    // bubbles, W=8 H=3
    clr_counts();
    do_start(3'd1, 3);
    send_pixels(0, 24, 1'b1);
    wait_done();
    chk("bubble_windows", win_cnt, 6);
    chk("bubble_lb_en", en_cnt, 24);
    chk("bubble_done", done_cnt, 1);

    // short image H=2
    clr_counts();
    do_start(3'd0, 2);
    send_pixels(0, 8, 1'b0);
    wait_done();
    chk("short_windows", win_cnt, 0);
    chk("short_no_win_valid", seen_first, 0);
    chk("short_lb_en", en_cnt, 8);
    chk("short_done", done_cnt, 1);

    // reset after pixel 7, then a clean frame
    clr_counts();
    do_start(3'd0, 4);
    send_pixels(0, 7, 1'b0);
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_lb_en", en_cnt, 7);
    chk("abort_idle", busy, 0);
    clr_counts();
    push_4x4_windows();
    do_start(3'd0, 4);
    send_pixels(100, 16, 1'b0);
    wait_done();
    chk("after_rst_windows", win_cnt, 4);
    chk("after_rst_done", done_cnt, 1);
    chk("after_rst_scoreboard_empty", exp_q.size(), 0);

    // start pulsed mid-frame with a different configuration
    clr_counts();
    push_4x4_windows();
    do_start(3'd0, 4);
    send_pixels(0, 5, 1'b0);
    do_start(3'd1, 2);
    send_pixels(5, 11, 1'b0);
    wait_done();
    chk("midstart_windows", win_cnt, 4);
    chk("midstart_lb_en", en_cnt, 16);
    chk("midstart_done", done_cnt, 1);
    chk("midstart_lb_sel", lb_sel, 0);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/linebuffer_3x3_ctrl.md
# linebuffer_3x3_ctrl

Sequencer for the 3x3 line buffer. It accepts a raster-order pixel stream under a valid/ready handshake, drives the line buffer's `sel`, `ifmap_stream` and shift-enable, and tracks row and column position. It flags each cycle on which `ifmap_3x3` holds a complete in-image window and gives that window's coordinates. It sits between the feature-map fetch path and the convolution PE array, and is started once per feature map.

## Interface
Parameters:
- `DATA_W` = 8: pixel width.
- `CNT_W` = 9: row/column counter width (max width 512).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; latches configuration; ignored unless IDLE.
- `cfg_sel`  in  3  width code; row width W = 4 << cfg_sel (4..512).
- `cfg_height`  in  CNT_W  image height H, in rows.
- `in_valid`  in  1  upstream pixel valid.
- `in_data`  in  DATA_W  upstream pixel.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `lb_sel`  out  3  to line buffer `sel`; the latched `cfg_sel`.
- `lb_en`  out  1  line buffer shift enable; high exactly on accept cycles.
- `lb_data`  out  DATA_W  to line buffer `ifmap_stream`; equals `in_data`.
- `win_valid`  out  1  `ifmap_3x3` holds a valid window.
- `win_ready`  in  1  downstream consumes the window.
- `win_row`, `win_col`  out  CNT_W  top-left coordinate of the current window.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse at end of frame.

## Operation
- States and transitions:
  - IDLE: on `start`, latch `cfg_sel` and `cfg_height`, clear counters, go to RUN.
  - RUN: accept pixels. The column counter `c` runs 0..W-1, then wraps to 0 and increments the row counter `r`. On accepting pixel (H-1, W-1), go to DRAIN.
  - DRAIN: wait until `!win_valid || win_ready`, then go to DONE.
  - DONE: pulse `done`, go to IDLE.
- `in_ready` = (state == RUN) && (!win_valid || win_ready). The line buffer never shifts under an unconsumed window.
- `lb_en` = `in_valid && in_ready` (combinational). `lb_data` = `in_data` (combinational pass-through).
- Window flag: an accepted pixel at (r, c) with r ≥ 2 and c ≥ 2 sets `win_valid` at the next edge, with `win_row` = r-2 and `win_col` = c-2.
- Otherwise `win_valid` clears when `win_ready` is high.
- Windows spanning the row wrap (c < 2) are never flagged. Windows per frame = (W-2)·(H-2).
- `cfg_height` < 3: all H·W pixels are still consumed, no window is flagged, and `done` still pulses.
- `start` while busy is ignored. Configuration changes after `start` have no effect until the next frame.
- Reset values: `in_ready`, `lb_en`, `win_valid`, `busy`, `done` = 0; `lb_sel`, `win_row`, `win_col` = 0; state = IDLE.
- Reset asserted mid-frame aborts the frame. No `done` is issued. Line buffer contents are don't-care; the next frame refills them.

## Timing
- `lb_en` is in the same cycle as the accept. `win_valid` follows one cycle after the accepting edge, matching the line buffer's registered output.
- Sustained throughput: one pixel per clock while `win_ready` is held high.
- Backpressure: `win_valid && !win_ready` holds `in_ready` = 0. `win_*` outputs and the line buffer contents stay frozen.
- Simultaneous window consume and new accept: allowed. `win_valid` stays 1 with updated coordinates.
- `done` comes one cycle after leaving DRAIN. `busy` falls in the same cycle `done` rises.

## Configuration
- Macro `LB_CTRL_STRIDE2_EN`:
  - Defined: adds input `cfg_stride2` (1 bit, latched at `start`). When it is 1, windows are flagged only where both r-2 and c-2 are even. Rows and columns still shift every pixel.
  - Undefined: the port is absent and stride is fixed at 1.

## Structure
- Shared package `lb_pkg`:
  - state enum `lb_ctrl_state_e` (IDLE, RUN, DRAIN, DONE);
  - constant `LB_WIN_K` = 3;
  - function `lb_width(sel)` returning 4 << sel.
- One sub-module, `lb_rc_counter`: column/row counter with wrap at W, last-pixel flag, and in-window flag.

## Test plan
- Basic frame: `cfg_sel`=0 (W=4), H=4, 16 pixels 0..15, `win_ready` held 1 → 4 windows.
  - Coordinates (0,0), (0,1), (1,0), (1,1).
  - First `win_valid` comes the cycle after pixel 10 is accepted.
  - `done` pulses once.
- Backpressure: same frame with `win_ready` low for 5 cycles on the first window → `in_ready` = 0 for those cycles, `win_row`/`win_col` stable, no pixel lost.
- Bubbles: `in_valid` toggled every other cycle, W=8, H=3 → exactly 6 windows, `lb_en` count = 24.
- Short image: H=2, W=4 → 8 pixels consumed, zero `win_valid`, `done` pulses.
- Reset at pixel 7 of a W=4, H=4 frame, then a new `start` → all outputs at reset values, no `done` from the aborted frame, then 4 correct windows.
- `start` pulsed mid-RUN → ignored; configuration unchanged; window count is still correct.
